// File: rtl/lc3b_mem_unit.sv
// LC-3b load/store sequencer: takes one request from the control path and runs it
// against a handshaked memory port. Covers word, byte and indirect (pointer) accesses.
module lc3b_mem_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(LANES);

    localparam logic [2:0] OP_LDW  = 3'd0;
    localparam logic [2:0] OP_LDB  = 3'd1;
    localparam logic [2:0] OP_LDBS = 3'd2;
    localparam logic [2:0] OP_STW  = 3'd3;
    localparam logic [2:0] OP_STB  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_STI  = 3'd6;

    typedef enum logic [1:0] {IDLE, PTR, ACC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]        be_q, be_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;

    logic [7:0]              rd_byte [LANES];
    logic [7:0]              lane_byte;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign rd_byte[gi] = mem_rdata[gi*8 +: 8];
    end

    // Lane comes from the final address, so indirect byte ops would use the pointer.
    assign lane_byte = rd_byte[addr_q[LSB-1:0]];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        read_d  = read_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    wdata_d = (req_op == OP_STB) ? {LANES{req_wdata[7:0]}} : req_wdata;
                    be_d    = (req_op == OP_STB) ? (LANES'(1) << req_addr[LSB-1:0]) : '1;
                    case (req_op)
                        OP_LDI, OP_STI: begin
                            state_d = PTR;
                            read_d  = 1'b1;
                        end
                        OP_LDW, OP_LDB, OP_LDBS: begin
                            state_d = ACC;
                            read_d  = 1'b1;
                        end
                        OP_STW, OP_STB: begin
                            state_d = ACC;
                            write_d = 1'b1;
                        end
                        default: begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            PTR: begin
                if (mem_resp) begin
                    addr_d  = mem_rdata[ADDR_WIDTH-1:0];
                    state_d = ACC;
                    read_d  = (op_q == OP_LDI);
                    write_d = (op_q == OP_STI);
                end
            end
            ACC: begin
                if (mem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    case (op_q)
                        OP_LDW, OP_LDI: rdata_d = mem_rdata;
                        OP_LDB:         rdata_d = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
                        OP_LDBS:        rdata_d = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
                        default:        rdata_d = '0;
                    endcase
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == DONE);
    assign resp_data       = rdata_q;
    assign resp_err        = err_q;
    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_address     = {addr_q[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Directed bench for lc3b_mem_unit: table of single-access vectors plus
// hand-written sequences for delayed response, indirect ops, illegal op and reset.
module tb_lc3b_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_resp = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_mem_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        exp_write;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request on the falling edge; returns 1ns after the accepting edge (T1).
    task automatic send(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = $urandom_range(0, 7);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        chk("ready_low_T1", req_ready, 0);
    endtask

    task automatic apply_vec(input vec_t v);
        send(v.op, v.addr, v.wdata);
        chk({v.name, "_read"},  mem_read,  !v.exp_write);
        chk({v.name, "_write"}, mem_write, v.exp_write);
        chk({v.name, "_addr"},  mem_address, v.exp_addr);
        chk({v.name, "_be"},    mem_byte_enable, v.exp_be);
        if (v.exp_write) chk({v.name, "_wdata"}, mem_wdata, v.exp_wdata);
        chk({v.name, "_novalid_T1"}, resp_valid, 0);
        mem_rdata = v.rdata;
        mem_resp  = 1'b1;
        @(posedge clk);
        #1;
        mem_resp  = 1'b0;
        mem_rdata = 16'($urandom);
        chk({v.name, "_valid_T2"}, resp_valid, 1);
        chk({v.name, "_data"},     resp_data, v.exp_data);
        chk({v.name, "_err"},      resp_err, 0);
        chk({v.name, "_strobe_drop"}, {mem_read, mem_write}, 0);
        chk({v.name, "_ready_T2"}, req_ready, 0);
        @(posedge clk);
        #1;
        chk({v.name, "_valid_T3"}, resp_valid, 0);
        chk({v.name, "_ready_T3"}, req_ready, 1);
        chk({v.name, "_data_held"}, resp_data, v.exp_data);
    endtask

    initial begin
        vecs[0] = '{"ldw",      3'd0, 16'h1235, 16'h0000, 16'hBEEF, 1'b0, 16'h1234, 2'b11, 16'h0000, 16'hBEEF};
        vecs[1] = '{"ldb_hi",   3'd1, 16'h0041, 16'h0000, 16'h8012, 1'b0, 16'h0040, 2'b11, 16'h0000, 16'h0080};
        vecs[2] = '{"ldbs_hi",  3'd2, 16'h0041, 16'h0000, 16'h8012, 1'b0, 16'h0040, 2'b11, 16'h0000, 16'hFF80};
        vecs[3] = '{"ldb_lo",   3'd1, 16'h0040, 16'h0000, 16'h8012, 1'b0, 16'h0040, 2'b11, 16'h0000, 16'h0012};
        vecs[4] = '{"ldbs_lo",  3'd2, 16'h0040, 16'h0000, 16'h8012, 1'b0, 16'h0040, 2'b11, 16'h0000, 16'h0012};
        vecs[5] = '{"stw",      3'd3, 16'h2223, 16'h1357, 16'hFFFF, 1'b1, 16'h2222, 2'b11, 16'h1357, 16'h0000};
        vecs[6] = '{"stb_lo",   3'd4, 16'h0100, 16'h00A5, 16'hFFFF, 1'b1, 16'h0100, 2'b01, 16'hA5A5, 16'h0000};
        vecs[7] = '{"ldbs_neg", 3'd2, 16'h0040, 16'h0000, 16'h00F0, 1'b0, 16'h0040, 2'b11, 16'h0000, 16'hFFF0};

        // Reset state
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", resp_valid, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_byte_enable, 0);
        chk("rst_data", resp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray mem_resp while idle must be ignored
        mem_resp = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        chk("idle_resp_ignored", {resp_valid, req_ready, mem_read}, 3'b010);

        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i]);
            $display("vector %0d %s done", i, vecs[i].name);
        end

        // STB to odd byte with response arriving in the third strobe cycle
        send(3'd4, 16'h0101, 16'h00A5);
        for (int c = 0; c < 3; c++) begin
            chk("stb_delay_write", mem_write, 1);
            chk("stb_delay_read", mem_read, 0);
            chk("stb_delay_be", mem_byte_enable, 2'b10);
            chk("stb_delay_wdata", mem_wdata, 16'hA5A5);
            chk("stb_delay_addr", mem_address, 16'h0100);
            chk("stb_delay_novalid", resp_valid, 0);
            if (c == 2) mem_resp = 1'b1;
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
        end
        chk("stb_delay_valid", resp_valid, 1);
        chk("stb_delay_data", resp_data, 0);
        chk("stb_delay_drop", mem_write, 0);
        $display("sequence stb delayed done");
        @(posedge clk);
        #1;

        // LDI: pointer read then data read, strobe held across both
        send(3'd5, 16'h0200, 16'h0000);
        chk("ldi_ptr_read", mem_read, 1);
        chk("ldi_ptr_addr", mem_address, 16'h0200);
        mem_rdata = 16'h3000;
        mem_resp  = 1'b1;
        @(posedge clk);
        #1;
        chk("ldi_acc_read", mem_read, 1);
        chk("ldi_acc_addr", mem_address, 16'h3000);
        chk("ldi_novalid_T2", resp_valid, 0);
        mem_rdata = 16'h7777;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        chk("ldi_valid_T3", resp_valid, 1);
        chk("ldi_data", resp_data, 16'h7777);
        chk("ldi_drop", mem_read, 0);
        $display("sequence ldi done");
        @(posedge clk);
        #1;

        // STI through a misaligned pointer
        send(3'd6, 16'h0202, 16'h4321);
        chk("sti_ptr_read", {mem_read, mem_write}, 2'b10);
        chk("sti_ptr_addr", mem_address, 16'h0202);
        mem_rdata = 16'h3001;
        mem_resp  = 1'b1;
        @(posedge clk);
        #1;
        chk("sti_acc_write", {mem_read, mem_write}, 2'b01);
        chk("sti_acc_addr", mem_address, 16'h3000);
        chk("sti_acc_be", mem_byte_enable, 2'b11);
        chk("sti_acc_wdata", mem_wdata, 16'h4321);
        mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        chk("sti_valid_T3", resp_valid, 1);
        chk("sti_data", resp_data, 0);
        $display("sequence sti done");
        @(posedge clk);
        #1;

        // Illegal op
        send(3'd7, 16'h1111, 16'h2222);
        chk("op7_valid_T1", resp_valid, 1);
        chk("op7_err", resp_err, 1);
        chk("op7_data", resp_data, 0);
        chk("op7_nostrobe", {mem_read, mem_write}, 0);
        @(posedge clk);
        #1;
        chk("op7_valid_T2", resp_valid, 0);
        chk("op7_ready_T2", req_ready, 1);
        chk("op7_err_held", resp_err, 1);
        $display("sequence illegal op done");

        // Reset while waiting in ACC
        send(3'd0, 16'h0500, 16'h0000);
        chk("rstmid_read_before", mem_read, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_read_drop", mem_read, 0);
        chk("rstmid_ready", req_ready, 1);
        chk("rstmid_addr", mem_address, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rstmid_no_valid", resp_valid, 0);
            chk("rstmid_ready_after", req_ready, 1);
        end
        $display("sequence reset mid-access done");
        apply_vec(vecs[0]);
        $display("vector post-reset ldw done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_unit.md
Name: lc3b_mem_unit

Overview:
- Parametrised load/store sequencer between the LC-3b control path and a handshaked memory port.
- Replaces the single MAR/MDR byte-lane muxing with a request/response unit.
- Supports word, byte (zero- or sign-extended) and indirect (LDI/STI) accesses across DATA_WIDTH/8 byte lanes.
- Holds its own address/data registers and waits on mem_resp, so the control FSM issues one request and waits for one response.

Parameters:
- DATA_WIDTH, 16: word width in bits; a multiple of 8, and at least 16.
- ADDR_WIDTH, 16: byte address width; must be ≤ DATA_WIDTH so indirect pointers fit.
- LANES, DATA_WIDTH/8: derived, not overridable; number of byte lanes.
- LSB, log2(LANES): derived; number of address bits that select a lane.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  0 LDW, 1 LDB (zero-ext), 2 LDBS (sign-ext), 3 STW, 4 STB, 5 LDI, 6 STI, 7 illegal.
- req_addr  in  ADDR_WIDTH  byte address; for LDI/STI, the address of the pointer.
- req_wdata  in  DATA_WIDTH  store data; STB uses bits [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; set only for op 7.
- mem_read  out  1  memory read strobe, held until mem_resp.
- mem_write  out  1  memory write strobe, held until mem_resp.
- mem_address  out  ADDR_WIDTH  word-aligned address; low LSB bits are always 0.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_byte_enable  out  LANES  write lane mask; all ones during reads.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_resp is high.
- mem_resp  in  1  memory completion.

Behaviour:
- Reset (async, rst_n low): state IDLE; all registers 0.
  - Outputs during reset: req_ready=1, resp_valid=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, resp_data=0.
  - Reset mid-access drops the strobes immediately and abandons the access; no response is ever issued for it.
- Handshake: req_ready=1 only in IDLE. Transfer occurs when req_valid && req_ready at a rising edge.
  - On transfer, latch op, address and write data.
  - The inputs are don't-care at all other times.
- States: IDLE, PTR, ACC, DONE.
  - IDLE → PTR on an LDI/STI transfer.
  - IDLE → ACC on a transfer of ops 0-4.
  - IDLE → DONE on a transfer of op 7 (resp_err=1). No strobe is asserted for op 7.
  - PTR: mem_read=1 at the pointer address. On mem_resp, latch mem_rdata[ADDR_WIDTH-1:0] as the new address, then go to ACC.
  - ACC: mem_read=1 for LDW/LDB/LDBS/LDI; mem_write=1 for STW/STB/STI. Stay until mem_resp, latch read data, then go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE. resp_data/resp_err are held until the next transfer.
- Latency: accept edge T0. Strobe asserted from T1. If mem_resp arrives in the first strobe cycle, resp_valid is high in T2 (T3 for LDI/STI). req_ready returns the cycle after resp_valid.
- Strobe timing: strobes are registered, glitch-free and stable while waiting.
  - mem_resp sampled in IDLE or DONE is ignored.
  - Strobes drop in the cycle after mem_resp.
- Lane select: lane = address[LSB-1:0], taken from the final address, i.e. after the pointer for indirect ops.
- Word ops (LDW, STW, LDI, STI): the low address bits are ignored, so misalignment is silently aligned.
  - Loads return the whole word.
  - STW/STI drive mem_byte_enable all ones.
- LDB: resp_data = zero-extended byte from the lane.
- LDBS: resp_data = sign-extended byte from the lane.
- STB: mem_wdata = req_wdata[7:0] replicated into every lane; mem_byte_enable is one-hot at the lane.
- Back-to-back requests: the earliest next acceptance is in the IDLE cycle after DONE; req_valid held high is accepted then.

Test Plan:
- Reset, then LDW 0x1235 with mem_rdata=0xBEEF and mem_resp in the first cycle → mem_address=0x1234, mem_byte_enable=2'b11; resp_valid at T2 with 0xBEEF; req_ready low T0+1..T2.
- LDB/LDBS 0x0041 with mem_rdata=0x8012 → mem_address=0x0040; LDB gives resp_data=0x0080; LDBS gives 0xFF80. At 0x0040: LDB gives 0x0012, LDBS gives 0x0012.
- STB 0x0101 with wdata=0x00A5 → mem_write=1, mem_wdata=0xA5A5, byte_enable=2'b10. mem_resp delayed 3 cycles → strobe held 3 cycles; resp_valid with data 0.
- LDI 0x0200, pointer read returns 0x3000, second read returns 0x7777 → two reads at 0x0200 then 0x3000; resp_data=0x7777. STI through pointer 0x3001 → write at 0x3000, byte_enable=2'b11.
- Op 7 → no strobe; resp_valid=1 and resp_err=1 at T1; resp_data=0.
- rst_n low while ACC is waiting → mem_read drops asynchronously; no resp_valid; req_ready=1 after release; a new LDW then completes normally.
